music_box_record_writer: RTL and testbench

- Record stage of the music box; the upstream producer for the playback stage.
- While the main state controller selects the record state, samples audioInput at 22.05 kHz and writes one 16-bit sample per SDRAM word, starting at address 0.
- Playback later reads the same address range.
- A small FIFO decouples the fixed sample rate from SDRAM busy periods. stateComplete is raised once all samples are committed.

---
 rtl/music_box_pkg.sv | 19 +
 rtl/record_sample_fifo.sv | 48 ++++
 rtl/music_box_record_writer.sv | 108 ++++++++++
 tb/tb_music_box_record_writer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/music_box_pkg.sv
// music_box_pkg: shared state codes, record FSM type and sample-rate constants for the music box
// No ports; imported by the record writer and its sample FIFO.
package music_box_pkg;
  localparam logic [4:0] IDLE_STATE_CODE = 5'd0;
  localparam logic [4:0] RECORD_STATE_CODE = 5'd2;
  localparam int CLOCK_HZ = 50_000_000;
  localparam int SAMPLE_RATE_HZ = 22_050;
  localparam int SAMPLE_DIV = (CLOCK_HZ + SAMPLE_RATE_HZ / 2) / SAMPLE_RATE_HZ;
  localparam int RECORD_SECONDS = 10;
  localparam int MAX_SAMPLES = SAMPLE_RATE_HZ * RECORD_SECONDS;
  localparam int FIFO_DEPTH = 8;
  localparam int IDX_W = 19;
  localparam int ENTRY_W = IDX_W + 16;
  typedef enum logic [2:0] {REC_IDLE, REC_ARM, REC_RECORD, REC_DRAIN, REC_DONE} rec_state_e;
  // -32768 has no positive twin in 16 bits, so it saturates to 32767
  function automatic logic [15:0] sat_abs(input logic [15:0] s);
    return s[15] ? ((s == 16'h8000) ? 16'h7fff : -s) : s;
  endfunction
endpackage

// File: rtl/record_sample_fifo.sv
// record_sample_fifo: synchronous FIFO of {captureIndex, sample} entries between sample tick and SDRAM writes
// Ports: clock_50Mhz, reset_n (async active-low), flush (empties FIFO), push/din, pop/dout (head),
// full, empty. A push while full is honoured only when a pop happens in the same cycle.
module record_sample_fifo
  import music_box_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int W = ENTRY_W
) (
  input  logic         clock_50Mhz,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clock_50Mhz or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= din;
        wp <= wp + AW'(1);
      end
      if (rd) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/music_box_record_writer.sv
// music_box_record_writer: samples audioInput at the sample rate while recording and writes one sample per SDRAM word
// Ports: clock_50Mhz, reset_n (async active-low), mainState (enables on RECORD_STATE), audioInput,
// stateComplete, overflow (sticky drop flag), samplesWritten, debugString, and the SDRAM write
// command interface sdram_* (inputAddress/writeData/isWriting/inputValid out, recievedCommand/isBusy in).
// Optional: define RECORD_PEAK_METER_EN to report the saturated peak |audioInput| in debugString[31:16].
module music_box_record_writer
  import music_box_pkg::*;
#(
  parameter int SAMPLE_DIV = music_box_pkg::SAMPLE_DIV,
  parameter int MAX_SAMPLES = music_box_pkg::MAX_SAMPLES,
  parameter int FIFO_DEPTH = music_box_pkg::FIFO_DEPTH,
  parameter logic [4:0] RECORD_STATE = RECORD_STATE_CODE
) (
  input  logic        clock_50Mhz,
  input  logic        reset_n,
  input  logic [4:0]  mainState,
  input  logic [15:0] audioInput,
  output logic        stateComplete,
  output logic        overflow,
  output logic [18:0] samplesWritten,
  output logic [31:0] debugString,
  output logic [24:0] sdram_inputAddress,
  output logic [15:0] sdram_writeData,
  output logic        sdram_isWriting,
  output logic        sdram_inputValid,
  input  logic        sdram_recievedCommand,
  input  logic        sdram_isBusy
);
  localparam int CW = $clog2(SAMPLE_DIV + 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(MAX_SAMPLES);
  rec_state_e state, state_d;
  logic [CW-1:0] tick_cnt;
  logic [IDX_W-1:0] capture_index;
  logic [ENTRY_W-1:0] head;
  logic run, tick, accept, issue, flush, fifo_full, fifo_empty;
  assign run = mainState == RECORD_STATE;
  assign tick = state == REC_RECORD && tick_cnt == TICK_LAST && capture_index != IDX_END;
  assign accept = sdram_inputValid && sdram_recievedCommand;
  // a command is pending while inputValid is high, so issuing only from !inputValid also gives the idle gap after each accept
  assign issue = run && (state == REC_RECORD || state == REC_DRAIN) && !fifo_empty && !sdram_inputValid && !sdram_isBusy;
  assign flush = !run || state == REC_ARM;
  assign stateComplete = state == REC_DONE;
  assign sdram_isWriting = sdram_inputValid;
  record_sample_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
    .clock_50Mhz(clock_50Mhz),
    .reset_n(reset_n),
    .flush(flush),
    .push(tick),
    .pop(accept),
    .din({capture_index, audioInput}),
    .dout(head),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  always_ff @(posedge clock_50Mhz or negedge reset_n)
    if (!reset_n) state <= REC_IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      REC_IDLE:   state_d = REC_ARM;
      REC_ARM:    state_d = REC_RECORD;
      REC_RECORD: state_d = capture_index == IDX_END ? REC_DRAIN : REC_RECORD;
      REC_DRAIN:  state_d = fifo_empty && !sdram_inputValid ? REC_DONE : REC_DRAIN;
      default:    state_d = state;
    endcase
    if (!run) state_d = REC_IDLE;
  end
  always_ff @(posedge clock_50Mhz or negedge reset_n)
    if (!reset_n) begin
      tick_cnt <= '0;
      capture_index <= '0;
      overflow <= 1'b0;
      samplesWritten <= '0;
      sdram_inputValid <= 1'b0;
      sdram_inputAddress <= '0;
      sdram_writeData <= '0;
    end else begin
      tick_cnt <= (state == REC_RECORD && tick_cnt != TICK_LAST) ? tick_cnt + CW'(1) : '0;
      if (state == REC_ARM) begin
        capture_index <= '0;
        overflow <= 1'b0;
        samplesWritten <= '0;
      end else begin
        // the index advances even for a dropped sample so later samples keep time-correct addresses
        if (tick) capture_index <= capture_index + IDX_W'(1);
        if (tick && fifo_full && !accept) overflow <= 1'b1;
        if (accept) samplesWritten <= samplesWritten + 19'd1;
      end
      sdram_inputValid <= run && !accept && (sdram_inputValid || issue);
      if (issue) begin
        sdram_inputAddress <= {6'b0, head[ENTRY_W-1:16]};
        sdram_writeData <= head[15:0];
      end
    end
`ifdef RECORD_PEAK_METER_EN
  logic [15:0] peak, mag;
  assign mag = sat_abs(audioInput);
  always_ff @(posedge clock_50Mhz or negedge reset_n)
    if (!reset_n) peak <= '0;
    else if (state == REC_ARM) peak <= '0;
    else if (tick && mag > peak) peak <= mag;
  assign debugString = {peak, capture_index[15:0]};
`else
  assign debugString = {13'b0, capture_index};
`endif
endmodule

// File: tb/tb_music_box_record_writer.sv
// tb_music_box_record_writer: table-driven and randomized check of the record writer against a queue model
module tb_music_box_record_writer;
  localparam int SD = 4;
  localparam int MS = 16;
  localparam int FD = 4;
  localparam logic [4:0] RS = 5'd2;
  logic clock_50Mhz = 1'b0;
  logic reset_n, stateComplete, overflow, sdram_isWriting, sdram_inputValid;
  logic sdram_recievedCommand, sdram_isBusy;
  logic [4:0] mainState;
  logic [15:0] audioInput, sdram_writeData;
  logic [18:0] samplesWritten;
  logic [31:0] debugString;
  logic [24:0] sdram_inputAddress;
  always #5 clock_50Mhz = ~clock_50Mhz;
  music_box_record_writer #(.SAMPLE_DIV(SD), .MAX_SAMPLES(MS), .FIFO_DEPTH(FD), .RECORD_STATE(RS)) dut (
    .clock_50Mhz(clock_50Mhz),
    .reset_n(reset_n),
    .mainState(mainState),
    .audioInput(audioInput),
    .stateComplete(stateComplete),
    .overflow(overflow),
    .samplesWritten(samplesWritten),
    .debugString(debugString),
    .sdram_inputAddress(sdram_inputAddress),
    .sdram_writeData(sdram_writeData),
    .sdram_isWriting(sdram_isWriting),
    .sdram_inputValid(sdram_inputValid),
    .sdram_recievedCommand(sdram_recievedCommand),
    .sdram_isBusy(sdram_isBusy)
  );
  typedef struct {logic [18:0] idx; logic [15:0] dat;} ent_t;
  typedef struct {string nm; int blo; int bhi; int slo; int shi; int dly; int mode; int sw; int ov;} vec_t;
  ent_t q[$];
  vec_t tab[4];
  logic [15:0] dtab [MS];
  int n_chk, n_pass, n_acc, n_drop, peak;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask
  function automatic int sabs(input logic [15:0] s);
    int x = $signed(s);
    x = x < 0 ? -x : x;
    return x > 32767 ? 32767 : x;
  endfunction
  task automatic fill(input int mode);
    for (int k = 0; k < MS; k++) dtab[k] = mode == 0 ? 16'(3 * k) : mode == 1 ? 16'($urandom) : 16'(k + 1);
    if (mode == 2) begin
      dtab[2] = 16'd100;
      dtab[3] = 16'h8000;
      dtab[4] = 16'd5;
    end
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, " complete"}, stateComplete, 0);
    chk({nm, " overflow"}, overflow, 0);
    chk({nm, " written"}, samplesWritten, 0);
    chk({nm, " debug"}, debugString, 0);
    chk({nm, " addr"}, sdram_inputAddress, 0);
    chk({nm, " data"}, sdram_writeData, 0);
    chk({nm, " writing"}, sdram_isWriting, 0);
    chk({nm, " valid"}, sdram_inputValid, 0);
  endtask
  // cycle c counts edges since mainState went to RECORD: ARM at c=1, RECORD from c=2, tick j at c=5+4j
  task automatic run_rec(input string nm, input int blo, input int bhi, input int slo, input int shi,
                         input int dly, input bit rnd, input int abort_at, input int reset_at,
                         input int exp_sw, input int exp_ov);
    int vc = 0, k;
    bit vp = 0, ap = 0, bp = 0, done = 0;
    logic [24:0] a_p = '0;
    logic [15:0] d_p = '0;
    logic v, busy, recv;
    q.delete();
    n_acc = 0;
    n_drop = 0;
    peak = 0;
    @(negedge clock_50Mhz);
    mainState = RS;
    for (int c = 0; c < 3000 && !done; c++) begin
      v = sdram_inputValid;
      if (c == 2) begin
        chk({nm, " armed written"}, samplesWritten, 0);
        chk({nm, " armed overflow"}, overflow, 0);
      end
      if (ap) chk({nm, " gap after accept"}, v, 0);
      else if (vp) begin
        chk({nm, " valid held"}, v, 1);
        chk({nm, " addr held"}, sdram_inputAddress, a_p);
        chk({nm, " data held"}, sdram_writeData, d_p);
      end
      if (!vp && bp) chk({nm, " no new command after busy"}, v, 0);
      if (c == abort_at) begin
        chk({nm, " pending at abort"}, v, 1);
        mainState = 5'd0;
        sdram_recievedCommand = 1'b0;
        sdram_isBusy = 1'b0;
        @(negedge clock_50Mhz);
        chk({nm, " valid after abort"}, sdram_inputValid, 0);
        chk({nm, " complete after abort"}, stateComplete, 0);
        done = 1;
      end else if (c == reset_at) begin
        chk({nm, " pending in drain"}, v, 1);
        reset_n = 1'b0;
        #1;
        chk_zero({nm, " async reset"});
        mainState = 5'd0;
        sdram_recievedCommand = 1'b0;
        sdram_isBusy = 1'b0;
        @(negedge clock_50Mhz);
        reset_n = 1'b1;
        done = 1;
      end else if (stateComplete) begin
        sdram_recievedCommand = 1'b0;
        sdram_isBusy = 1'b0;
        chk({nm, " fifo model empty"}, q.size(), 0);
        chk({nm, " written vs accepts"}, samplesWritten, n_acc);
        chk({nm, " overflow vs drops"}, overflow, n_drop > 0);
        chk({nm, " valid at done"}, v, 0);
`ifdef RECORD_PEAK_METER_EN
        chk({nm, " debug"}, debugString, {16'(peak), 16'(MS)});
`else
        chk({nm, " debug"}, debugString, {13'b0, 19'(MS)});
`endif
        if (exp_sw >= 0) begin
          chk({nm, " written table"}, samplesWritten, exp_sw);
          chk({nm, " overflow table"}, overflow, exp_ov);
        end
        @(negedge clock_50Mhz);
        chk({nm, " complete held"}, stateComplete, 1);
        mainState = 5'd0;
        @(negedge clock_50Mhz);
        chk({nm, " complete cleared"}, stateComplete, 0);
        done = 1;
      end else begin
        busy = rnd ? ($urandom_range(0, 3) == 0) : (c >= blo && c < bhi);
        vc = v ? (vp ? vc + 1 : 0) : 0;
        recv = v && !busy && !(c >= slo && c < shi) && vc >= dly;
        k = c < 3 ? 0 : (c - 3) / 4;
        if (k > MS - 1) k = MS - 1;
        audioInput = dtab[k];
        sdram_isBusy = busy;
        sdram_recievedCommand = recv;
        if (recv) begin
          chk({nm, " command has queued sample"}, q.size() > 0, 1);
          if (q.size() > 0) begin
            chk({nm, " write addr"}, sdram_inputAddress, {6'b0, q[0].idx});
            chk({nm, " write data"}, sdram_writeData, q[0].dat);
            void'(q.pop_front());
          end
          n_acc++;
        end
        if (c >= 5 && (c - 5) % 4 == 0 && (c - 5) / 4 < MS) begin
          if (q.size() < FD) q.push_back('{19'((c - 5) / 4), dtab[(c - 5) / 4]});
          else n_drop++;
          if (sabs(dtab[(c - 5) / 4]) > peak) peak = sabs(dtab[(c - 5) / 4]);
        end
        ap = recv;
        bp = busy;
        vp = v;
        a_p = sdram_inputAddress;
        d_p = sdram_writeData;
        @(negedge clock_50Mhz);
      end
    end
    chk({nm, " finished within budget"}, done, 1);
  endtask
  initial begin
    n_chk = 0;
    n_pass = 0;
    reset_n = 1'b1;
    mainState = 5'd0;
    audioInput = '0;
    sdram_recievedCommand = 1'b0;
    sdram_isBusy = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(negedge clock_50Mhz);
    reset_n = 1'b1;
    tab[0] = '{"basic", -1, -1, -1, -1, 1, 0, 16, 0};
    tab[1] = '{"busy", 21, 31, -1, -1, 1, 0, 16, 0};
    tab[2] = '{"stall", -1, -1, 0, 30, 1, 0, 13, 1};
    tab[3] = '{"peak", -1, -1, -1, -1, 0, 2, 16, 0};
    for (int i = 0; i < 4; i++) begin
      fill(tab[i].mode);
      run_rec(tab[i].nm, tab[i].blo, tab[i].bhi, tab[i].slo, tab[i].shi, tab[i].dly, 1'b0, -1, -1, tab[i].sw, tab[i].ov);
    end
    fill(0);
    run_rec("abort", -1, -1, 30, 40, 1, 1'b0, 33, -1, -1, 0);
    repeat (3) @(negedge clock_50Mhz);
    run_rec("reenter", -1, -1, -1, -1, 1, 1'b0, -1, -1, 16, 0);
    run_rec("drain reset", -1, -1, 50, 200, 1, 1'b0, -1, 72, -1, 0);
    repeat (2) @(negedge clock_50Mhz);
    for (int r = 0; r < 4; r++) begin
      fill(1);
      run_rec("random", -1, -1, -1, -1, int'($urandom_range(0, 3)), 1'b1, -1, -1, -1, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
